mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: port A (CPU) and port B (debug/DMA)
// share the memory with round-robin ties, a bounded B burst lock and per-port grant counters.
module mem_arbiter #(
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_req_i,
  input  logic        a_we_i,
  input  logic [15:0] a_addr_i,
  input  logic [15:0] a_wdata_i,
  output logic        a_gnt_o,
  output logic        a_rvalid_o,
  output logic [15:0] a_rdata_o,
  input  logic        b_req_i,
  input  logic        b_we_i,
  input  logic        b_lock_i,
  input  logic [15:0] b_addr_i,
  input  logic [15:0] b_wdata_i,
  output logic        b_gnt_o,
  output logic        b_rvalid_o,
  output logic [15:0] b_rdata_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i,
  input  logic        cnt_clr_i,
  output logic [15:0] a_cnt_o,
  output logic [15:0] b_cnt_o
);

  localparam logic [7:0] MaxLock = 8'(MAX_LOCK);

  typedef enum logic {
    PortA = 1'b0,
    PortB = 1'b1
  } port_e;

  port_e       lastGnt_q, lastGnt_d;
  logic [7:0]  lockCnt_q, lockCnt_d;
  logic        aRvalid_q, aRvalid_d, bRvalid_q, bRvalid_d;
  logic [15:0] aRdata_q, aRdata_d, bRdata_q, bRdata_d;
  logic [15:0] aCnt_q, aCnt_d, bCnt_q, bCnt_d;
  logic        aGnt, bGnt, lockActive;

  // A nonzero lockCnt_q implies the previous cycle was a locked B grant.
  always_comb begin
    aGnt       = 1'b0;
    bGnt       = 1'b0;
    lockActive = (lastGnt_q == PortB) && (lockCnt_q != 8'd0) && (lockCnt_q < MaxLock);
    if (!rst_i) begin
      if (a_req_i && b_req_i) begin
        if (lockActive)              bGnt = 1'b1;
        else if (lastGnt_q == PortB) aGnt = 1'b1;
        else                         bGnt = 1'b1;
      end else if (a_req_i) begin
        aGnt = 1'b1;
      end else if (b_req_i) begin
        bGnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = 16'h0000;
    mem_wdata_o = 16'h0000;
    if (aGnt) begin
      mem_we_o    = a_we_i;
      mem_addr_o  = a_addr_i;
      mem_wdata_o = a_wdata_i;
    end else if (bGnt) begin
      mem_we_o    = b_we_i;
      mem_addr_o  = b_addr_i;
      mem_wdata_o = b_wdata_i;
    end
  end

  always_comb begin
    lastGnt_d = lastGnt_q;
    if (aGnt)      lastGnt_d = PortA;
    else if (bGnt) lastGnt_d = PortB;

    lockCnt_d = 8'd0;
    if (bGnt && b_lock_i) lockCnt_d = (lockCnt_q == 8'hFF) ? 8'hFF : lockCnt_q + 8'd1;

    aRvalid_d = aGnt && !a_we_i;
    bRvalid_d = bGnt && !b_we_i;
    aRdata_d  = aRvalid_d ? mem_rdata_i : aRdata_q;
    bRdata_d  = bRvalid_d ? mem_rdata_i : bRdata_q;

    aCnt_d = aCnt_q;
    bCnt_d = bCnt_q;
    if (cnt_clr_i) begin
      aCnt_d = 16'h0000;
      bCnt_d = 16'h0000;
    end else begin
      if (aGnt && aCnt_q != 16'hFFFF) aCnt_d = aCnt_q + 16'd1;
      if (bGnt && bCnt_q != 16'hFFFF) bCnt_d = bCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lastGnt_q <= PortB;
      lockCnt_q <= 8'd0;
      aRvalid_q <= 1'b0;
      bRvalid_q <= 1'b0;
      aRdata_q  <= 16'h0000;
      bRdata_q  <= 16'h0000;
      aCnt_q    <= 16'h0000;
      bCnt_q    <= 16'h0000;
    end else begin
      lastGnt_q <= lastGnt_d;
      lockCnt_q <= lockCnt_d;
      aRvalid_q <= aRvalid_d;
      bRvalid_q <= bRvalid_d;
      aRdata_q  <= aRdata_d;
      bRdata_q  <= bRdata_d;
      aCnt_q    <= aCnt_d;
      bCnt_q    <= bCnt_d;
    end
  end

  // Read responses are masked while reset is held so a read granted just before reset never surfaces.
  assign a_gnt_o    = aGnt;
  assign b_gnt_o    = bGnt;
  assign a_rvalid_o = aRvalid_q && !rst_i;
  assign b_rvalid_o = bRvalid_q && !rst_i;
  assign a_rdata_o  = rst_i ? 16'h0000 : aRdata_q;
  assign b_rdata_o  = rst_i ? 16'h0000 : bRdata_q;
  assign a_cnt_o    = aCnt_q;
  assign b_cnt_o    = bCnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural arbitration/memory model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_arbiter;

  localparam int MaxLock = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aReq = 1'b0, aWe = 1'b0, bReq = 1'b0, bWe = 1'b0, bLock = 1'b0, cntClr = 1'b0;
  logic [15:0] aAddr = 16'h0, aWdata = 16'h0, bAddr = 16'h0, bWdata = 16'h0;
  logic        aGnt, aRvalid, bGnt, bRvalid, memWe;
  logic [15:0] aRdata, bRdata, memAddr, memWdata, memRdata, aCnt, bCnt;

  logic [15:0] mem [0:65535];
  logic        memInit = 1'b0;

  int passed = 0;
  int total  = 0;

  // Model state: last winner (1 = B), length of the current locked-B run, counters, read responses.
  logic        mLastB  = 1'b1;
  int          mStreak = 0;
  int          mAcnt   = 0;
  int          mBcnt   = 0;
  logic        mArv    = 1'b0;
  logic        mBrv    = 1'b0;
  logic [15:0] mArd    = 16'h0;
  logic [15:0] mBrd    = 16'h0;

  mem_arbiter #(.MAX_LOCK(MaxLock)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(aReq), .a_we_i(aWe), .a_addr_i(aAddr), .a_wdata_i(aWdata),
    .a_gnt_o(aGnt), .a_rvalid_o(aRvalid), .a_rdata_o(aRdata),
    .b_req_i(bReq), .b_we_i(bWe), .b_lock_i(bLock), .b_addr_i(bAddr), .b_wdata_i(bWdata),
    .b_gnt_o(bGnt), .b_rvalid_o(bRvalid), .b_rdata_o(bRdata),
    .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_wdata_o(memWdata), .mem_rdata_i(memRdata),
    .cnt_clr_i(cntClr), .a_cnt_o(aCnt), .b_cnt_o(bCnt)
  );

  always #5 clk = ~clk;

  assign memRdata = mem[memAddr];

  // 0 = no grant, 1 = A, 2 = B, derived from the arbitration rules and the current inputs.
  function automatic int expWinner();
    if (rst) return 0;
    if (aReq && bReq) begin
      if (mLastB && mStreak > 0 && mStreak < MaxLock) return 2;
      return mLastB ? 1 : 2;
    end
    if (aReq) return 1;
    if (bReq) return 2;
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    else
      passed++;
  endtask

  task automatic applyStimulus(input logic ar, input logic aw, input logic [15:0] aa, input logic [15:0] ad,
                               input logic br, input logic bw, input logic bl,
                               input logic [15:0] ba, input logic [15:0] bd);
    aReq = ar; aWe = aw; aAddr = aa; aWdata = ad;
    bReq = br; bWe = bw; bLock = bl; bAddr = ba; bWdata = bd;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expectGrant(input string name, input int who);
    @(negedge clk);
    checkOutput({name, "_aGnt"}, {15'b0, aGnt}, {15'b0, who == 1});
    checkOutput({name, "_bGnt"}, {15'b0, bGnt}, {15'b0, who == 2});
  endtask

  // Memory model and reference update on every rising edge.
  always @(posedge clk) begin
    int w;
    w = expWinner();
    if (!memInit) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 16'(i) ^ 16'hA5A5;
      memInit <= 1'b1;
    end else if (memWe) begin
      mem[memAddr] <= memWdata;
    end
    if (rst) begin
      mLastB <= 1'b1; mStreak <= 0; mAcnt <= 0; mBcnt <= 0;
      mArv <= 1'b0; mBrv <= 1'b0; mArd <= 16'h0; mBrd <= 16'h0;
    end else begin
      mArv <= (w == 1) && !aWe;
      mBrv <= (w == 2) && !bWe;
      if (w == 1 && !aWe) mArd <= mem[aAddr];
      if (w == 2 && !bWe) mBrd <= mem[bAddr];
      mStreak <= (w == 2 && bLock) ? mStreak + 1 : 0;
      if (w != 0) mLastB <= (w == 2);
      if (cntClr) begin
        mAcnt <= 0; mBcnt <= 0;
      end else begin
        if (w == 1 && mAcnt < 65535) mAcnt <= mAcnt + 1;
        if (w == 2 && mBcnt < 65535) mBcnt <= mBcnt + 1;
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    int w;
    w = expWinner();
    checkOutput("aGnt", {15'b0, aGnt}, {15'b0, w == 1});
    checkOutput("bGnt", {15'b0, bGnt}, {15'b0, w == 2});
    checkOutput("memWe", {15'b0, memWe}, {15'b0, (w == 1) ? aWe : (w == 2) ? bWe : 1'b0});
    checkOutput("memAddr", memAddr, (w == 1) ? aAddr : (w == 2) ? bAddr : 16'h0);
    checkOutput("memWdata", memWdata, (w == 1) ? aWdata : (w == 2) ? bWdata : 16'h0);
    checkOutput("aRvalid", {15'b0, aRvalid}, {15'b0, mArv && !rst});
    checkOutput("bRvalid", {15'b0, bRvalid}, {15'b0, mBrv && !rst});
    checkOutput("aRdata", aRdata, rst ? 16'h0 : mArd);
    checkOutput("bRdata", bRdata, rst ? 16'h0 : mBrd);
    checkOutput("aCnt", aCnt, 16'(mAcnt));
    checkOutput("bCnt", bCnt, 16'(mBcnt));
  end

  initial begin
    int rrPat[4]   = '{1, 2, 1, 2};
    int lockPat[12] = '{1, 2, 2, 2, 2, 2, 2, 2, 2, 1, 2, 2};

    // Reset with both ports requesting writes: nothing may be granted or written.
    applyStimulus(1'b1, 1'b1, 16'h0050, 16'hBEEF, 1'b1, 1'b1, 1'b0, 16'h0060, 16'hCAFE);
    @(negedge clk);
    checkOutput("rstAGnt", {15'b0, aGnt}, 16'h0);
    checkOutput("rstBGnt", {15'b0, bGnt}, 16'h0);
    checkOutput("rstMemWe", {15'b0, memWe}, 16'h0);
    nextCycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    checkOutput("initACnt", aCnt, 16'h0);
    checkOutput("initBCnt", bCnt, 16'h0);
    checkOutput("initARvalid", {15'b0, aRvalid}, 16'h0);
    checkOutput("initBRdata", bRdata, 16'h0);
    nextCycle();

    // Round-robin between two continuous readers.
    applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
    for (int i = 0; i < 4; i++) begin
      expectGrant("rr", rrPat[i]);
      nextCycle();
    end
    idle();
    @(negedge clk);
    checkOutput("rrBRvalid", {15'b0, bRvalid}, 16'h1);
    checkOutput("rrBRdata", bRdata, 16'hA595);
    checkOutput("rrARdataHeld", aRdata, 16'hA585);
    checkOutput("rrACnt", aCnt, 16'd2);
    checkOutput("rrBCnt", bCnt, 16'd2);
    nextCycle();

    // A writes, B reads the same address the next cycle.
    applyStimulus(1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    expectGrant("wrA", 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
    expectGrant("rdB", 2);
    checkOutput("rawARvalid0", {15'b0, aRvalid}, 16'h0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("rawBRvalid", {15'b0, bRvalid}, 16'h1);
    checkOutput("rawBRdata", bRdata, 16'h1234);
    checkOutput("rawARvalid1", {15'b0, aRvalid}, 16'h0);
    nextCycle();

    // Locked B burst against a continuous A request, from a fresh reset.
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0070, 16'h0, 1'b1, 1'b0, 1'b1, 16'h0080, 16'h0);
    for (int i = 0; i < 12; i++) begin
      expectGrant("lock", lockPat[i]);
      nextCycle();
    end

    // Idle after a B grant: bus quiet, then a tie goes to A.
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("idleMemWe", {15'b0, memWe}, 16'h0);
      checkOutput("idleMemAddr", memAddr, 16'h0);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0);
    expectGrant("tieAfterIdle", 1);
    nextCycle();

    // Reset right after an A read grant.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'h0090, 16'h5555, 1'b1, 1'b1, 1'b0, 16'h00A0, 16'h6666);
    @(negedge clk);
    checkOutput("midRstARvalid", {15'b0, aRvalid}, 16'h0);
    checkOutput("midRstARdata", aRdata, 16'h0);
    checkOutput("midRstAGnt", {15'b0, aGnt}, 16'h0);
    checkOutput("midRstBGnt", {15'b0, bGnt}, 16'h0);
    checkOutput("midRstMemWe", {15'b0, memWe}, 16'h0);
    nextCycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    checkOutput("postRstARvalid", {15'b0, aRvalid}, 16'h0);
    checkOutput("postRstARdata", aRdata, 16'h0);
    nextCycle();

    // Saturate the A counter, then clear it during a simultaneous A grant.
    applyStimulus(1'b1, 1'b1, 16'h0100, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (65540) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("satACnt", aCnt, 16'hFFFF);
    nextCycle();
    cntClr = 1'b1;
    expectGrant("clrGrant", 1);
    nextCycle();
    cntClr = 1'b0;
    idle();
    @(negedge clk);
    checkOutput("clrACnt", aCnt, 16'h0);
    checkOutput("clrBCnt", bCnt, 16'h0);
    nextCycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
